pc_pipe: RTL

//  Parametrised program-counter unit: generates the fetch PC and carries each
//  PC down a NUM_STAGES-deep shift pipeline with per-stage valid bits.

---
 rtl/pc_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/pc_pipe.sv
// Program-counter unit: fetch PC generation plus an NUM_STAGES-deep PC/valid shift pipeline
// with stall bubbles, redirect flush and a saturating redirect counter. Optional: PC_MISALIGN_TRAP_EN.
module pc_pipe #(
  parameter int               XLEN        = 32,
  parameter int               NUM_STAGES  = 3,
  parameter logic [XLEN-1:0]  RESET_VEC   = 32'h0100_0000,
  parameter int               STALL_STAGE = 1,
  parameter int               CNT_W       = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_target,
  output logic [NUM_STAGES*XLEN-1:0] pc_stage,
  output logic [NUM_STAGES-1:0]      valid_stage,
  output logic [CNT_W-1:0]           redirect_count,
  output logic                       misalign_trap
);

  localparam logic [XLEN-1:0]       PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [NUM_STAGES-1:0] VALID_RST = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  logic [NUM_STAGES-1:0][XLEN-1:0] pc_q, pc_d;
  logic [NUM_STAGES-1:0]           valid_q, valid_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            trap_q, trap_d;
  logic                            take_redirect;

  // Next-state: stage 0 fetch PC, younger-stage shift/hold/bubble, counter and trap.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    trap_d  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned target flushes younger stages but leaves stage 0 on its own path.
    take_redirect = redirect && (redirect_target[1:0] == 2'b00);
    if (redirect && (redirect_target[1:0] != 2'b00)) begin
      trap_d = 1'b1;
    end else begin
      trap_d = 1'b0;
    end
`else
    take_redirect = redirect;
`endif

    if (take_redirect) begin
      pc_d[0]    = redirect_target;
      valid_d[0] = 1'b1;
    end else if (stall) begin
      pc_d[0]    = pc_q[0];
      valid_d[0] = valid_q[0];
    end else begin
      pc_d[0]    = pc_q[0] + PC_STEP;
      valid_d[0] = 1'b1;
    end

    for (int k = 1; k < NUM_STAGES; k++) begin
      if (redirect) begin
        pc_d[k]    = pc_q[k-1];
        valid_d[k] = 1'b0;
      end else if (!stall || (k > STALL_STAGE + 1)) begin
        pc_d[k]    = pc_q[k-1];
        valid_d[k] = valid_q[k-1];
      end else if (k == STALL_STAGE + 1) begin
        pc_d[k]    = pc_q[k-1];
        valid_d[k] = 1'b0;
      end else begin
        pc_d[k]    = pc_q[k];
        valid_d[k] = valid_q[k];
      end
    end

    if (take_redirect && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= {NUM_STAGES{RESET_VEC}};
      valid_q <= VALID_RST;
      cnt_q   <= {CNT_W{1'b0}};
      trap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign pc_stage       = pc_q;
  assign valid_stage    = valid_q;
  assign redirect_count = cnt_q;
  assign misalign_trap  = trap_q;

endmodule
